pmbist_controller: RTL and testbench
====================================

// Module: pmbist_controller
// PURPOSE
//  Sequencer for the pattern_generator datapath and the memory under test. Steps
//  the generator through every (submit, shift) combination with single-cycle
//  sbmt/shft strobes. For each pattern: write it to all addresses, read them back,
//  compare. Reports done/fail, first-failure info and a saturating error count.
//  rst is shared with pattern_generator, so both leave reset in step.
// PARAMETERS
//  AW        4   memory address width; 2**AW words tested per pattern
//  DW        8   data width; equals pattern_generator ptrn_out width
//  GW        5   generator counter width; 2**GW submits per column
//  NUM_COL   5   generator mux columns (selcnt modulus)
//  NUM_SHIFT 5   generator tiler shifts (tilcnt modulus)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   reset, asynchronous, active-high
//  start      in   1   begin a run; sampled only in IDLE or DONE
//  busy       out  1   high in all states except IDLE and DONE
//  done       out  1   high in DONE; cleared by start or rst
//  fail       out  1   sticky: at least one miscompare this run
//  err_count  out  8   miscompares this run, saturates at 8'hFF
//  fail_addr  out  AW  address of first miscompare
//  fail_exp   out  DW  expected data at first miscompare
//  fail_act   out  DW  read data at first miscompare
//  sbmt_out   out  1   to generator sbmt_in: one-cycle pulse per pattern advance
//  shft_out   out  1   to generator shft_in: one-cycle pulse per shift advance
//  ptrn_in    in   DW  from generator ptrn_out
//  mem_addr   out  AW  memory address
//  mem_we     out  1   memory write enable
//  mem_wdata  out  DW  write data; equals ptrn_in during WRITE
//  mem_re     out  1   memory read enable
//  mem_rdata  in   DW  read data, valid one clk after mem_re
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0. All counters 0.
//  Loop counters: addr (AW bits), sub_cnt (0..NUM_COL*2**GW-1 = 0..159), shf_cnt (0..NUM_SHIFT-1).
//  FSM, one transition per clk:
//   IDLE/DONE --start--> SETTLE. Clears fail, err_count, fail_* and done. Sets addr=0.
//   SETTLE: 1 cycle; lets ptrn_in settle after a strobe. Next state WRITE.
//   WRITE: mem_we=1, mem_addr=addr, one word per cycle. Expected pattern is latched on entry.
//     At addr=2**AW-1: addr<=0, next READ.
//   READ: mem_re=1, mem_addr=addr, one word per cycle. Compare stage is a 1-cycle pipeline:
//     the addr is registered and mem_rdata is checked the next cycle.
//     At the last addr, next DRAIN.
//   DRAIN: 1 cycle; compares the last read word.
//     If sub_cnt<159: next ADV_SBMT. Else if shf_cnt<NUM_SHIFT-1: next ADV_SHFT. Else next ADV_END.
//   ADV_SBMT: sbmt_out=1; sub_cnt++; next SETTLE.
//   ADV_SHFT: sbmt_out=1 and shft_out=1 in the same cycle. The sbmt wraps the generator
//     count to 0 and selcnt back to 0. sub_cnt<=0, shf_cnt++, next SETTLE.
//   ADV_END: same strobes as ADV_SHFT; returns the generator to its reset state. Next DONE.
//  Strobes are registered, glitch-free, and high for exactly one clk.
//  Compare: a miscompare is mem_rdata != latched expected.
//   On a miscompare, err_count increments, saturating at 8'hFF.
//   On the first miscompare of a run, fail<=1 and fail_addr/fail_exp/fail_act are captured.
//     These hold until the next start.
//  Totals per run: P = NUM_SHIFT*NUM_COL*2**GW = 800 patterns.
//   Cycles per pattern = 2*2**AW+3 = 35.
//   done rises exactly P*35 = 28000 clks after the start-sampling edge.
//   Pulse counts: sbmt_out 800, shft_out 5.
//  start while busy is ignored. rst mid-run aborts to IDLE with all outputs 0; the generator is reset too.
//  start in DONE restarts immediately; done drops on the next clk.
// TESTING
//  T1 clean run, ideal RAM model: start -> done=1 at +28000 clks, fail=0, err_count=0,
//     800 sbmt pulses, 5 shft pulses. Generator count/selcnt/tilcnt all 0 at DONE.
//  T2 stuck-at-1 on bit 3 at addr 5: fail=1, fail_addr=5, fail_exp=8'h00,
//     fail_act=8'h08 (captured in the first pattern).
//  T3 RAM returns ~wdata on every read: err_count saturates at 8'hFF, fail_addr=0,
//     fail_exp=8'h00, fail_act=8'hFF; run still reaches DONE at 28000.
//  T4 start pulsed at clk 100 while busy: ignored; done timing is unchanged.
//  T5 rst asserted during READ of pattern 37: all outputs 0 asynchronously.
//     A new start then gives a clean T1 result.
//  T6 start in DONE after a failing run: fail, err_count and fail_* clear.
//     With a fault-free RAM, the second run reports fail=0.

Source files
------------

// File: rtl/pmbist_controller_if.sv
// rtl/pmbist_controller_if.sv - generator strobe/pattern and memory bus bundle for pmbist_controller
//
// Purpose: groups the signals between the BIST sequencer, the pattern
// generator and the memory under test.
// Ports (signals):
//   sbmt_out  : sequencer -> generator, one-cycle pattern advance strobe
//   shft_out  : sequencer -> generator, one-cycle shift advance strobe
//   ptrn_in   : generator -> sequencer, current pattern (DW bits)
//   mem_addr  : sequencer -> memory, word address (AW bits)
//   mem_we    : sequencer -> memory, write enable
//   mem_wdata : sequencer -> memory, write data (DW bits)
//   mem_re    : sequencer -> memory, read enable
//   mem_rdata : memory -> sequencer, read data, valid one clk after mem_re
// Modports: master = sequencer side, slave = generator/memory side.

interface pmbist_controller_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          sbmt_out;
    logic          shft_out;
    logic [DW-1:0] ptrn_in;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;

    modport master (
        output sbmt_out,
        output shft_out,
        input  ptrn_in,
        output mem_addr,
        output mem_we,
        output mem_wdata,
        output mem_re,
        input  mem_rdata
    );

    modport slave (
        input  sbmt_out,
        input  shft_out,
        output ptrn_in,
        input  mem_addr,
        input  mem_we,
        input  mem_wdata,
        input  mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/pmbist_controller.sv
// rtl/pmbist_controller.sv - memory BIST sequencer driving the pattern generator and memory under test
//
// Purpose: walks the pattern generator through every (submit, shift)
// combination; for each pattern writes it to every address, reads every
// address back and compares against the pattern latched at write start.
// Reports done, sticky fail, saturating error count and first-failure info.
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset (shared with the generator)
//   start     : begin a run; honoured only in IDLE or DONE
//   busy      : run in progress (not IDLE, not DONE)
//   done      : run complete; cleared by start or rst
//   fail      : at least one miscompare this run
//   err_count : miscompares this run, saturating at 8'hFF
//   fail_addr : address of first miscompare
//   fail_exp  : expected data of first miscompare
//   fail_act  : read data of first miscompare
//   bus       : generator strobes/pattern and memory bus (master side)

module pmbist_controller #(
    parameter int AW        = 4,
    parameter int DW        = 8,
    parameter int GW        = 5,
    parameter int NUM_COL   = 5,
    parameter int NUM_SHIFT = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic [7:0]          err_count,
    output logic [AW-1:0]       fail_addr,
    output logic [DW-1:0]       fail_exp,
    output logic [DW-1:0]       fail_act,
    pmbist_controller_if.master bus
);

    localparam int SUB_N = NUM_COL * (2 ** GW);
    localparam int SW    = (SUB_N > 1) ? $clog2(SUB_N) : 1;
    localparam int HW    = (NUM_SHIFT > 1) ? $clog2(NUM_SHIFT) : 1;

    localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};
    localparam logic [SW-1:0] SUB_LAST  = SW'(SUB_N - 1);
    localparam logic [HW-1:0] SHF_LAST  = HW'(NUM_SHIFT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETTLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_ADV_SBMT,
        S_ADV_SHFT,
        S_ADV_END,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [HW-1:0] shf_q, shf_d;
    logic          run_clear;

    logic          sbmt_q, shft_q;
    logic          rd_valid_q;
    logic [AW-1:0] rd_addr_q;
    logic [DW-1:0] exp_q;
    logic          fail_q;
    logic [7:0]    err_q;
    logic [AW-1:0] fail_addr_q;
    logic [DW-1:0] fail_exp_q;
    logic [DW-1:0] fail_act_q;
    logic          miscmp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            sub_q   <= '0;
            shf_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sub_q   <= sub_d;
            shf_q   <= shf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        sub_d     = sub_q;
        shf_d     = shf_q;
        run_clear = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_SETTLE;
                    addr_d    = '0;
                    sub_d     = '0;
                    shf_d     = '0;
                    run_clear = 1'b1;
                end
            end
            S_SETTLE: state_d = S_WRITE;
            S_WRITE: begin
                if (addr_q == ADDR_LAST) begin
                    addr_d  = '0;
                    state_d = S_READ;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            S_READ: begin
                if (addr_q == ADDR_LAST) begin
                    addr_d  = '0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                if (sub_q < SUB_LAST) begin
                    state_d = S_ADV_SBMT;
                end else if (shf_q < SHF_LAST) begin
                    state_d = S_ADV_SHFT;
                end else begin
                    state_d = S_ADV_END;
                end
            end
            S_ADV_SBMT: begin
                sub_d   = sub_q + SW'(1);
                state_d = S_SETTLE;
            end
            S_ADV_SHFT: begin
                sub_d   = '0;
                shf_d   = shf_q + HW'(1);
                state_d = S_SETTLE;
            end
            S_ADV_END: begin
                sub_d   = '0;
                shf_d   = '0;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are flops loaded from the next state, so each is high exactly
    // for the one cycle spent in an ADV state and never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbmt_q <= 1'b0;
            shft_q <= 1'b0;
        end else begin
            sbmt_q <= (state_d == S_ADV_SBMT) || (state_d == S_ADV_SHFT) ||
                      (state_d == S_ADV_END);
            shft_q <= (state_d == S_ADV_SHFT) || (state_d == S_ADV_END);
        end
    end

    // Read data arrives one clk after mem_re, so the address is carried one
    // stage and the compare happens in the following cycle (DRAIN covers the
    // last word).
    assign miscmp = rd_valid_q && (bus.mem_rdata != exp_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q  <= 1'b0;
            rd_addr_q   <= '0;
            exp_q       <= '0;
            fail_q      <= 1'b0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
        end else begin
            rd_valid_q <= (state_q == S_READ);
            rd_addr_q  <= addr_q;
            // ptrn_in has had the SETTLE cycle to respond to the last strobe.
            if (state_q == S_SETTLE) begin
                exp_q <= bus.ptrn_in;
            end
            if (run_clear) begin
                fail_q      <= 1'b0;
                err_q       <= '0;
                fail_addr_q <= '0;
                fail_exp_q  <= '0;
                fail_act_q  <= '0;
            end else if (miscmp) begin
                if (err_q != 8'hFF) begin
                    err_q <= err_q + 8'd1;
                end
                if (!fail_q) begin
                    fail_q      <= 1'b1;
                    fail_addr_q <= rd_addr_q;
                    fail_exp_q  <= exp_q;
                    fail_act_q  <= bus.mem_rdata;
                end
            end
        end
    end

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign fail      = fail_q;
    assign err_count = err_q;
    assign fail_addr = fail_addr_q;
    assign fail_exp  = fail_exp_q;
    assign fail_act  = fail_act_q;

    assign bus.sbmt_out  = sbmt_q;
    assign bus.shft_out  = shft_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_we    = (state_q == S_WRITE);
    assign bus.mem_re    = (state_q == S_READ);
    assign bus.mem_wdata = (state_q == S_WRITE) ? bus.ptrn_in : '0;

endmodule

// File: tb/tb_pmbist_controller.sv
// tb/tb_pmbist_controller.sv - scoreboard bench for pmbist_controller with generator and RAM models

module tb_pmbist_controller;

    localparam int AW      = 4;
    localparam int DW      = 8;
    localparam int GW      = 5;
    localparam int NC      = 5;
    localparam int NS      = 5;
    localparam int RUN_CYC = 28000;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, fail;
    logic [7:0]    err_count;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_exp, fail_act;

    pmbist_controller_if #(.AW(AW), .DW(DW)) bus ();

    pmbist_controller #(
        .AW(AW), .DW(DW), .GW(GW), .NUM_COL(NC), .NUM_SHIFT(NS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .err_count (err_count),
        .fail_addr (fail_addr),
        .fail_exp  (fail_exp),
        .fail_act  (fail_act),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pattern generator model: count wraps into selcnt (mod NC); shft steps tilcnt (mod NS).
    // Pattern = {selcnt, count} rotated left by tilcnt; zero out of reset.
    logic [4:0]  g_cnt;
    logic [2:0]  g_sel;
    logic [2:0]  g_til;
    logic [7:0]  g_v;
    logic [15:0] g_dbl;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            g_cnt <= '0;
            g_sel <= '0;
            g_til <= '0;
        end else begin
            if (bus.sbmt_out) begin
                if (g_cnt == 5'd31) begin
                    g_cnt <= '0;
                    g_sel <= (g_sel == 3'(NC - 1)) ? 3'd0 : g_sel + 3'd1;
                end else begin
                    g_cnt <= g_cnt + 5'd1;
                end
            end
            if (bus.shft_out) begin
                g_til <= (g_til == 3'(NS - 1)) ? 3'd0 : g_til + 3'd1;
            end
        end
    end

    always_comb begin
        g_v         = {g_sel, g_cnt};
        g_dbl       = {g_v, g_v} << g_til;
        bus.ptrn_in = g_dbl[15:8];
    end

    // RAM model with selectable fault: 0 ideal, 1 bit3 stuck-at-1 at addr 5, 2 inverted reads.
    int            fault_mode = 0;
    logic [DW-1:0] mem [16];

    function automatic logic [DW-1:0] ram_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
        case (fault_mode)
            1:       return (a == 4'd5) ? (d | 8'h08) : d;
            2:       return ~d;
            default: return d;
        endcase
    endfunction

    initial bus.mem_rdata = '0;
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= ram_read(bus.mem_addr, mem[bus.mem_addr]);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    typedef struct {
        int            done_cyc;
        logic          fail;
        logic [7:0]    err;
        logic [AW-1:0] faddr;
        logic [DW-1:0] fexp;
        logic [DW-1:0] fact;
        int            sbmt;
        int            shft;
    } exp_t;

    exp_t sb_q[$];

    task automatic push_exp(input int dc, input logic f, input logic [7:0] e,
                            input logic [AW-1:0] fa, input logic [DW-1:0] fe,
                            input logic [DW-1:0] fc);
        exp_t x;
        x.done_cyc = dc;
        x.fail     = f;
        x.err      = e;
        x.faddr    = fa;
        x.fexp     = fe;
        x.fact     = fc;
        x.sbmt     = 800;
        x.shft     = 5;
        sb_q.push_back(x);
    endtask

    // Monitor: counts strobes per run and scores each completed run on done rising.
    int   sbmt_n = 0, shft_n = 0, long_n = 0;
    logic prev_busy = 1'b0, prev_done = 1'b0, prev_sbmt = 1'b0, prev_shft = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (busy && !prev_busy) begin
            sbmt_n = 0;
            shft_n = 0;
            long_n = 0;
        end
        if (bus.sbmt_out) begin
            sbmt_n++;
            if (prev_sbmt) long_n++;
        end
        if (bus.shft_out) begin
            shft_n++;
            if (prev_shft) long_n++;
        end
        if (done && !prev_done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("done_cycle",  cyc,       e.done_cyc);
                chk("fail",        fail,      e.fail);
                chk("err_count",   err_count, e.err);
                chk("fail_addr",   fail_addr, e.faddr);
                chk("fail_exp",    fail_exp,  e.fexp);
                chk("fail_act",    fail_act,  e.fact);
                chk("sbmt_pulses", sbmt_n,    e.sbmt);
                chk("shft_pulses", shft_n,    e.shft);
                chk("long_strobe", long_n,    0);
                chk("gen_at_rest", {g_cnt, g_sel, g_til}, 0);
            end
        end
        prev_busy = busy;
        prev_done = done;
        prev_sbmt = bus.sbmt_out;
        prev_shft = bus.shft_out;
    end

    task automatic do_start(output int s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < RUN_CYC + 2000) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            chk("done_timeout", 32'd0, 32'd1);
            if (sb_q.size() != 0) void'(sb_q.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_fail"},  fail, 0);
        chk({tag, "_err"},   err_count, 0);
        chk({tag, "_faddr"}, fail_addr, 0);
        chk({tag, "_fexp"},  fail_exp, 0);
        chk({tag, "_fact"},  fail_act, 0);
        chk({tag, "_we"},    bus.mem_we, 0);
        chk({tag, "_re"},    bus.mem_re, 0);
        chk({tag, "_addr"},  bus.mem_addr, 0);
        chk({tag, "_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_sbmt"},  bus.sbmt_out, 0);
        chk({tag, "_shft"},  bus.shft_out, 0);
    endtask

    initial begin
        int s;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Inverting RAM: every read miscompares; a stray start at +100 must be ignored.
        fault_mode = 2;
        do_start(s);
        push_exp(s + RUN_CYC, 1'b1, 8'hFF, 4'd0, 8'h00, 8'hFF);
        while (cyc < s + 100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_stray_start", busy, 1);
        wait_done();

        // Restart from DONE with a stuck bit; results clear on the next clk.
        fault_mode = 1;
        do_start(s);
        chk("restart_done",  done, 0);
        chk("restart_busy",  busy, 1);
        chk("restart_fail",  fail, 0);
        chk("restart_err",   err_count, 0);
        chk("restart_fact",  fail_act, 0);

        // Abort during READ of pattern 37 after checking first-failure capture.
        while (cyc < s + 35 * 37 + 20) @(negedge clk);
        chk("p37_in_read",   bus.mem_re, 1);
        chk("stuck_fail",    fail, 1);
        chk("stuck_faddr",   fail_addr, 5);
        chk("stuck_fexp",    fail_exp, 8'h00);
        chk("stuck_fact",    fail_act, 8'h08);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Clean run after the abort.
        fault_mode = 0;
        do_start(s);
        push_exp(s + RUN_CYC, 1'b0, 8'h00, 4'd0, 8'h00, 8'h00);
        wait_done();

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
